m_stage: RTL

Memory-access pipeline level of the 5-stage MIPS CPU. It sits between the E level and the W level, and holds the M pipeline register. It drives a req/ack data-memory/device bus with variable latency and stalls the pipeline while an access is outstanding. It also produces the byte enables and store-data alignment, sign/zero-extends load data into DR_out for W, flags address exceptions, and supplies M-stage forwarding values.

---
 rtl/m_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/m_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline: M pipeline register, req/ack
// data bus master with stall, store alignment, load extension, exceptions and forwarding.
module m_stage #(
    parameter logic [31:0] DM_END   = 32'h0000_3000,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV_END  = 32'h0000_7F20
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Reg_Rst,
    input  logic        We,
    input  logic [31:0] IR_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] Y_in,
    input  logic [31:0] RT_in,
    input  logic [31:0] HILO_in,
    input  logic [1:0]  ACmpB_in,
    input  logic [1:0]  ACmp0_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic [31:0] Y_out,
    output logic [31:0] HILO_out,
    output logic [1:0]  ACmpB_out,
    output logic [1:0]  ACmp0_out,
    output logic [31:0] DR_out,
    output logic [4:0]  M_RFA3_out,
    output logic [31:0] M_RFWD_out,
    output logic        M_Forward_Ready_out,
    output logic        Stall_out,
    output logic        Exc_out,
    output logic [4:0]  ExcCode_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    function automatic logic isLoadOp(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b100001) || (op == 6'b100101) ||
               (op == 6'b100000) || (op == 6'b100100);
    endfunction

    function automatic logic isStoreOp(input logic [5:0] op);
        return (op == 6'b101011) || (op == 6'b101001) || (op == 6'b101000);
    endfunction

    // Access size is encoded in opcode[1:0]: 11 word, 01 half, 00 byte.
    function automatic logic accessFault(input logic [1:0] size, input logic [31:0] addr);
        logic word, half, misaligned, inDm, inDev;
        word       = (size == 2'b11);
        half       = (size == 2'b01);
        misaligned = (word && (addr[1:0] != 2'b00)) || (half && addr[0]);
        inDm       = (addr < DM_END);
        inDev      = (addr >= DEV_BASE) && (addr < DEV_END);
        return misaligned || (!inDm && !inDev) || (inDev && !word);
    endfunction

    state_t      r_state, w_nextState;
    logic [31:0] r_ir, r_pc, r_y, r_rt, r_hilo, r_rdata;
    logic [1:0]  r_acmpB, r_acmp0;

    logic        w_stall, w_load, w_inMem, w_inFault;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic        w_isLoad, w_isStore, w_calR, w_calI, w_jLink, w_mf, w_mfc0, w_exc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_stall   = (r_state == ACCESS);
    assign w_load    = We & ~w_stall;
    assign w_inMem   = isLoadOp(IR_in[31:26]) | isStoreOp(IR_in[31:26]);
    assign w_inFault = accessFault(IR_in[27:26], Y_in);

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_isLoad  = isLoadOp(w_op);
    assign w_isStore = isStoreOp(w_op);
    assign w_calR    = (w_op == 6'b000000) &&
                       ((w_funct[5:3] == 3'b100) || (w_funct == 6'b101010) || (w_funct == 6'b101011) ||
                        ((w_funct[5:3] == 3'b000) && (w_funct != 6'b000001) && (w_funct != 6'b000101)));
    assign w_calI    = (w_op[5:3] == 3'b001);
    assign w_jLink   = (w_op == 6'b000011) || ((w_op == 6'b000000) && (w_funct == 6'b001001));
    assign w_mf      = (w_op == 6'b000000) && ((w_funct == 6'b010000) || (w_funct == 6'b010010));
    assign w_mfc0    = (w_op == 6'b010000) && (w_rs == 5'd0);
    assign w_exc     = (w_isLoad | w_isStore) && accessFault(w_op[1:0], r_y);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ir <= '0; r_pc <= '0; r_y <= '0; r_rt <= '0; r_hilo <= '0;
            r_acmpB <= '0; r_acmp0 <= '0;
        end else if (Reg_Rst) begin
            r_ir <= '0; r_pc <= '0; r_y <= '0; r_rt <= '0; r_hilo <= '0;
            r_acmpB <= '0; r_acmp0 <= '0;
        end else if (w_load) begin
            r_ir <= IR_in; r_pc <= PC_in; r_y <= Y_in; r_rt <= RT_in; r_hilo <= HILO_in;
            r_acmpB <= ACmpB_in; r_acmp0 <= ACmp0_in;
        end
    end

    // Read data is only captured while the request is live, so a late ack after a flush is dropped.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_rdata <= '0;
        else if (Reg_Rst || w_load)
            r_rdata <= '0;
        else if ((r_state == ACCESS) && mem_ack)
            r_rdata <= mem_rdata;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (Reg_Rst)
            w_nextState = IDLE;
        else if (w_load)
            w_nextState = (w_inMem && !w_inFault) ? ACCESS : IDLE;
        else if ((r_state == ACCESS) && mem_ack)
            w_nextState = DONE;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (r_state == ACCESS) begin
            mem_req  = 1'b1;
            mem_we   = w_isStore;
            mem_addr = {r_y[31:2], 2'b00};
            case (w_op)
                6'b101011: begin mem_be = 4'b1111; mem_wdata = r_rt; end
                6'b101001: begin mem_be = r_y[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{r_rt[15:0]}}; end
                6'b101000: begin mem_be = 4'b0001 << r_y[1:0]; mem_wdata = {4{r_rt[7:0]}}; end
                default:   begin mem_be = 4'b0000; mem_wdata = '0; end
            endcase
        end
    end

    assign w_byte = r_rdata[8*r_y[1:0] +: 8];
    assign w_half = r_y[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        DR_out = '0;
        case (w_op)
            6'b100011: DR_out = r_rdata;
            6'b100001: DR_out = {{16{w_half[15]}}, w_half};
            6'b100101: DR_out = {16'h0000, w_half};
            6'b100000: DR_out = {{24{w_byte[7]}}, w_byte};
            6'b100100: DR_out = {24'h000000, w_byte};
            default:   DR_out = '0;
        endcase
    end

    always_comb begin
        M_RFA3_out = 5'd0;
        if (w_calR || w_mf || (w_jLink && (w_op == 6'b000000)))
            M_RFA3_out = w_rd;
        else if (w_op == 6'b000011)
            M_RFA3_out = 5'd31;
        else if (w_calI || w_isLoad || w_mfc0)
            M_RFA3_out = w_rt;
    end

    assign M_RFWD_out          = w_jLink ? (r_pc + 32'd8) : r_y;
    assign M_Forward_Ready_out = w_calR | w_calI | w_jLink | w_mf;

    assign Stall_out   = w_stall;
    assign Exc_out     = w_exc;
    assign ExcCode_out = !w_exc ? 5'd0 : (w_isStore ? 5'd5 : 5'd4);

    assign IR_out    = r_ir;
    assign PC_out    = r_pc;
    assign Y_out     = r_y;
    assign HILO_out  = r_hilo;
    assign ACmpB_out = r_acmpB;
    assign ACmp0_out = r_acmp0;

endmodule
